hello_scroll_ctrl: RTL and testbench

//  Upstream sequencer for the 5-digit HELLO rotator: generates the 3-bit rotation index that drives the rotator's SW select.
//  - Advances the index automatically at a divided rate (auto-scroll), or manually on a debounced step strobe while paused.
//  - Supports scroll direction and a synchronous preset.
//  - Emits per-step and per-wrap pulses for downstream status LEDs.

---
 rtl/hello_scroll_ctrl_pkg.sv | 57 +++++
 rtl/hello_scroll_ctrl_sync_edge.sv | 30 +++
 rtl/hello_scroll_ctrl.sv | 93 +++++++++
 tb/tb_hello_scroll_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hello_scroll_ctrl_pkg.sv
// Shared types and constants for the HELLO scroll sequencer.
// Holds FSM encoding, step result bundle and position helpers.
package hello_scroll_ctrl_pkg;

  localparam int DEF_DIV  = 25000000;
  localparam int DEF_NPOS = 5;
  localparam int POS_W    = 3;

  typedef enum logic {
    ST_PAUSE = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic             wrap;
  } step_res_t;

  // One position step in either direction, wrapping at 0 / last.
  function automatic step_res_t step_pos(
    input logic [POS_W-1:0] pos,
    input logic             dir,
    input logic [POS_W-1:0] last
  );
    step_res_t r;
    r.pos  = pos;
    r.wrap = 1'b0;
    if (!dir) begin
      if (pos == last) begin
        r.pos  = '0;
        r.wrap = 1'b1;
      end else begin
        r.pos = pos + POS_W'(1);
      end
    end else begin
      if (pos == '0) begin
        r.pos  = last;
        r.wrap = 1'b1;
      end else begin
        r.pos = pos - POS_W'(1);
      end
    end
    return r;
  endfunction

  // Out-of-range presets collapse to 0 so POS never leaves 0..npos-1.
  function automatic logic [POS_W-1:0] load_pos(
    input logic [POS_W-1:0] val,
    input int               npos
  );
    logic [POS_W-1:0] r;
    if (int'(val) < npos) r = val;
    else                  r = '0;
    return r;
  endfunction

endpackage

// File: rtl/hello_scroll_ctrl_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge pulse.
// Ports: clk, rst (async high), din (async), pulse (1-cycle).
module hello_scroll_ctrl_sync_edge
  import hello_scroll_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      s3    <= s2;
      pulse <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/hello_scroll_ctrl.sv
// Rotation index sequencer for the 5-digit HELLO rotator.
// In: CLOCK_50 RST EN DIR STEP LOAD LOAD_VAL; Out: POS TICK WRAP.
module hello_scroll_ctrl
  import hello_scroll_ctrl_pkg::*;
#(
  parameter int DIV  = DEF_DIV,
  parameter int NPOS = DEF_NPOS
) (
  input  logic             CLOCK_50,
  input  logic             RST,
  input  logic             EN,
  input  logic             DIR,
  input  logic             STEP,
  input  logic             LOAD,
  input  logic [POS_W-1:0] LOAD_VAL,
  output logic [POS_W-1:0] POS,
  output logic             TICK,
  output logic             WRAP
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [POS_W-1:0] LAST = POS_W'(NPOS - 1);

  state_t           state;
  state_t           state_n;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_n;
  logic [POS_W-1:0] pos_n;
  logic             tick_n;
  logic             wrap_n;
  logic             man_step;
  logic             auto_step;
  logic             step;
  step_res_t        sr;

  hello_scroll_ctrl_sync_edge u_sync_edge (
    .clk   (CLOCK_50),
    .rst   (RST),
    .din   (STEP),
    .pulse (man_step)
  );

  always_comb begin
    state_n   = state;
    presc_n   = presc;
    pos_n     = POS;
    tick_n    = 1'b0;
    wrap_n    = 1'b0;
    auto_step = 1'b0;
    step      = 1'b0;
    sr        = step_pos(POS, DIR, LAST);

    unique case (state)
      ST_PAUSE: if (EN)  state_n = ST_RUN;
      ST_RUN:   if (!EN) state_n = ST_PAUSE;
    endcase

    auto_step = (state == ST_RUN) && (presc == PMAX);
    step = ((state == ST_RUN) && auto_step) ||
           ((state == ST_PAUSE) && man_step);

    // Cleared while paused so RUN always starts a full period.
    if (LOAD || state == ST_PAUSE) presc_n = '0;
    else if (presc == PMAX)        presc_n = '0;
    else                           presc_n = presc + PW'(1);

    if (LOAD) begin
      pos_n = load_pos(LOAD_VAL, NPOS);
    end else if (step) begin
      pos_n  = sr.pos;
      wrap_n = sr.wrap;
      tick_n = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state <= ST_PAUSE;
      presc <= '0;
      POS   <= '0;
      TICK  <= 1'b0;
      WRAP  <= 1'b0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      POS   <= pos_n;
      TICK  <= tick_n;
      WRAP  <= wrap_n;
    end
  end

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// Directed bench for hello_scroll_ctrl with DIV=4, NPOS=5.
// Vector table for stepping/loading, hand sequences for timing cases.
module tb_hello_scroll_ctrl;
  import hello_scroll_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       dir;
  logic       stp;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] pos;
  logic       tick;
  logic       wrap;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  hello_scroll_ctrl #(.DIV(4), .NPOS(5)) dut (
    .CLOCK_50 (clk),
    .RST      (rst),
    .EN       (en),
    .DIR      (dir),
    .STEP     (stp),
    .LOAD     (load),
    .LOAD_VAL (load_val),
    .POS      (pos),
    .TICK     (tick),
    .WRAP     (wrap)
  );

  typedef struct {
    logic       en;
    logic       dir;
    logic       load;
    logic [2:0] lval;
    logic [2:0] epos;
    logic       etick;
    logic       ewrap;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic e, input logic d, input logic l,
                      input logic [2:0] lv, input logic [2:0] ep,
                      input logic et, input logic ew);
    vec_t v;
    v.en = e; v.dir = d; v.load = l; v.lval = lv;
    v.epos = ep; v.etick = et; v.ewrap = ew;
    vq.push_back(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int up[5]  = '{1, 2, 3, 4, 0};
    int upw[5] = '{0, 0, 0, 0, 1};
    int dn[5]  = '{4, 3, 2, 1, 0};
    int dnw[5] = '{1, 0, 0, 0, 0};
    int n;
    int first;
    int ticks;
    int prev;

    // Expected table: enter RUN, five up steps, five down steps,
    // then presets including out-of-range and a LOAD on auto_step.
    push(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      prev = (k == 0) ? 0 : up[k-1];
      repeat (3) push(1, 0, 0, 0, 3'(prev), 0, 0);
      push(1, 0, 0, 0, 3'(up[k]), 1, 1'(upw[k]));
    end
    for (int k = 0; k < 5; k++) begin
      prev = (k == 0) ? 0 : dn[k-1];
      repeat (3) push(1, 1, 0, 0, 3'(prev), 0, 0);
      push(1, 1, 0, 0, 3'(dn[k]), 1, 1'(dnw[k]));
    end
    push(1, 0, 1, 3, 3, 0, 0);
    push(1, 0, 1, 6, 0, 0, 0);
    push(1, 0, 1, 4, 4, 0, 0);
    push(1, 0, 1, 5, 0, 0, 0);
    push(1, 0, 1, 3, 3, 0, 0);
    repeat (3) push(1, 0, 0, 0, 3, 0, 0);
    push(1, 0, 1, 2, 2, 0, 0);
    repeat (3) push(1, 0, 0, 0, 2, 0, 0);
    push(1, 0, 0, 0, 3, 1, 0);

    rst = 1'b1; en = 0; dir = 0; stp = 0; load = 0; load_val = 0;
    repeat (2) @(negedge clk);
    chk("rst_pos", pos, 0);
    chk("rst_tick", tick, 0);
    chk("rst_wrap", wrap, 0);
    rst = 1'b0;
    cyc();

    // Async reset while TICK is high mid-run.
    en = 1; load = 1; load_val = 3;
    cyc();
    chk("t1_load", pos, 3);
    load = 0;
    n = 0;
    while (!tick && n < 10) begin
      cyc();
      n++;
    end
    chk("t1_tick_seen", tick, 1);
    chk("t1_tick_lat", 8'(n), 4);
    chk("t1_pos_pre", pos, 4);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_pos", pos, 0);
    chk("t1_async_tick", tick, 0);
    chk("t1_async_wrap", wrap, 0);
    en = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("t1_quiet%0d_tick", i), tick, 0);
      chk($sformatf("t1_quiet%0d_pos", i), pos, 0);
    end

    foreach (vq[i]) begin
      en = vq[i].en;
      dir = vq[i].dir;
      load = vq[i].load;
      load_val = vq[i].lval;
      cyc();
      chk($sformatf("vec%0d_pos", i), pos, vq[i].epos);
      chk($sformatf("vec%0d_tick", i), tick, vq[i].etick);
      chk($sformatf("vec%0d_wrap", i), wrap, vq[i].ewrap);
    end
    load = 0;

    // EN drop at prescaler 2, then re-enter RUN.
    en = 1; dir = 0;
    cyc();
    cyc();
    en = 0;
    cyc();
    chk("t6_off0_tick", tick, 0);
    cyc();
    chk("t6_off1_tick", tick, 0);
    cyc();
    chk("t6_off_pos", pos, 3);
    en = 1;
    first = -1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (tick && first < 0) first = i;
    end
    chk("t6_first_step", 8'(first), 4);
    chk("t6_pos", pos, 4);

    // Held STEP in PAUSE yields one step after 4 edges.
    en = 0; load = 1; load_val = 0;
    cyc();
    load = 0;
    chk("t4_preset", pos, 0);
    cyc();
    cyc();
    stp = 1;
    first = -1;
    ticks = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (tick) begin
        ticks++;
        if (first < 0) first = i;
      end
    end
    chk("t4_lat", 8'(first), 4);
    chk("t4_ticks", 8'(ticks), 1);
    chk("t4_pos", pos, 1);
    stp = 0;
    repeat (4) cyc();
    chk("t4_release_pos", pos, 1);

    // STEP activity in RUN must not add steps.
    en = 1;
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      stp = (i < 8) ? i[1] : 1'b0;
      cyc();
      if (tick) ticks++;
    end
    chk("t4_run_ticks", 8'(ticks), 2);
    chk("t4_run_pos", pos, 3);
    en = 0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
